// File: rtl/result_reporter.sv
// Result reporter: captures each tap set found by the search engine into a small FIFO,
// restarts the search, and streams every stored result out as a framed byte stream.
module result_reporter #(
  parameter int         NUM_OF_TAPS = 16,
  parameter int         DEPTH       = 4,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       found,
  input  logic [NUM_OF_TAPS*8-1:0]   co_buf,
  output logic                       ext_res,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  output logic [1:0]                 dbg_state
);

  localparam int W  = NUM_OF_TAPS * 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;

  // Byte stream handshake: a byte moves when tx_valid & tx_ready are both high at a
  // rising edge; tx_valid/tx_data only change after such an accept (or on reset).
  typedef enum logic [1:0] {IDLE, SYNC, DATA, CHK} state_t;

  state_t          state, state_nxt;
  logic            found_q;
  logic            evt, full, push, pop;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [W-1:0]    mem [DEPTH];
  logic [W-1:0]    head;
  logic [IW-1:0]   idx, idx_nxt, idx_inc;
  logic [7:0]      csum, csum_nxt;
  logic [7:0]      tx_data_nxt;
  logic            tx_valid_nxt;
  logic            last;

  assign evt     = found & ~found_q;
  assign full    = (fifo_count == CW'(DEPTH));
  assign push    = evt & ~full;
  assign pop     = (state == CHK) & tx_ready;
  assign head    = mem[rd_ptr];
  assign idx_inc = idx + IW'(1);
  assign last    = (idx == IW'(NUM_OF_TAPS - 1));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= co_buf;
  end

  // Capture side: full is judged before any same-edge pop, so such a push is a drop.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      found_q    <= 1'b0;
      ext_res    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      found_q <= found;
      ext_res <= evt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (evt && full) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      idx      <= '0;
      csum     <= '0;
    end else begin
      state    <= state_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      idx      <= idx_nxt;
      csum     <= csum_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_count != '0) state_nxt = SYNC;
      SYNC:    if (tx_ready) state_nxt = DATA;
      DATA:    if (tx_ready && last) state_nxt = CHK;
      CHK:     if (tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are computed one step ahead so nothing combinational reaches the pins.
  always_comb begin
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    idx_nxt      = idx;
    csum_nxt     = csum;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = SYNC_BYTE;
          idx_nxt      = '0;
          csum_nxt     = '0;
        end
      end
      SYNC: begin
        if (tx_ready) tx_data_nxt = head[7:0];
      end
      DATA: begin
        if (tx_ready) begin
          csum_nxt = csum ^ tx_data;
          if (!last) begin
            idx_nxt     = idx_inc;
            tx_data_nxt = head[{idx_inc, 3'b000} +: 8];
          end else begin
            tx_data_nxt = csum ^ tx_data;
          end
        end
      end
      CHK: begin
        if (tx_ready) tx_valid_nxt = 1'b0;
      end
      default: tx_valid_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_result_reporter.sv
// Bench for result_reporter: directed scenarios plus a random phase, checked against a
// frame-level reference model (queue of expected bytes, FIFO occupancy and drop counts).
module tb_result_reporter;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int W     = N * 8;

  logic         clk;
  logic         res;
  logic         found;
  logic [W-1:0] co_buf;
  logic         ext_res;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [2:0]   fifo_count;
  logic         overflow;
  logic [7:0]   drop_count;
  logic [1:0]   dbg_state;

  logic         ready_manual;
  logic         ready_gen;
  int           ready_mode;   // 0 manual, 2 toggle, 3 random

  int pass_cnt  = 0;
  int total_cnt = 0;

  assign tx_ready = (ready_mode == 0) ? ready_manual : ready_gen;

  result_reporter #(.NUM_OF_TAPS(N), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .res(res), .found(found), .co_buf(co_buf), .ext_res(ext_res),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [W-1:0] val);
    co_buf = val;
    found  = 1'b1;
    step();
    found  = 1'b0;
    step();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (!(tx_valid == 1'b0 && fifo_count == 3'd0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("idle", {28'd0, tx_valid, fifo_count}, 32'd0);
  endtask

  initial begin
    ready_gen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) ready_gen = ~ready_gen;
      else ready_gen = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard: predicts post-edge values at each falling edge, checks them at the next
  logic [7:0] exp_q [$];
  int   m_cnt, m_fb, m_drop, frames_done, ext_pulses;
  logic m_prev_found, m_ovf, e_ext, m_evt, m_acc;
  logic hold_pend, gap_pend;
  logic [7:0] hold_data, x;

  initial begin
    m_cnt = 0; m_fb = 0; m_drop = 0; frames_done = 0; ext_pulses = 0;
    m_prev_found = 0; m_ovf = 0; e_ext = 0; hold_pend = 0; gap_pend = 0; hold_data = 0;
  end

  always @(negedge clk) begin
    if (!res) begin
      exp_q.delete();
      m_cnt = 0; m_fb = 0; m_drop = 0; m_prev_found = 0; m_ovf = 0;
      e_ext = 0; hold_pend = 0; gap_pend = 0;
    end else begin
      chk("fifo_count", 32'(fifo_count), 32'(m_cnt));
      chk("ext_res", 32'(ext_res), 32'(e_ext));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      if (hold_pend) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(hold_data));
      end
      if (gap_pend) chk("frame_gap", 32'(tx_valid), 32'd0);
      if (ext_res) ext_pulses++;

      m_evt = found && !m_prev_found;
      m_prev_found = found;
      m_acc = tx_valid && tx_ready;
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
      gap_pend = 1'b0;
      if (m_evt) begin
        if (m_cnt == DEPTH) begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end else begin
          m_cnt++;
          x = 8'h00;
          exp_q.push_back(8'hA5);
          for (int b = 0; b < N; b++) begin
            exp_q.push_back(co_buf[8*b +: 8]);
            x = x ^ co_buf[8*b +: 8];
          end
          exp_q.push_back(x);
        end
      end
      if (m_acc) begin
        if (exp_q.size() == 0) chk("spurious_byte", {24'd0, tx_data}, 32'h100);
        else chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        m_fb++;
        if (m_fb == N + 2) begin
          m_fb = 0;
          m_cnt--;
          frames_done++;
          gap_pend = 1'b1;
        end
      end
      e_ext = m_evt;
    end
  end

  logic [7:0] t1 [6];
  int f0, p0;

  initial begin
    t1 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    res = 1'b0; found = 1'b0; co_buf = '0; ready_manual = 1'b0; ready_mode = 0;
    repeat (2) step();
    chk("rst_ext_res", 32'(ext_res), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    res = 1'b1;
    step();

    // single result, sink always ready
    ready_manual = 1'b1;
    co_buf = 32'h04030201;
    found = 1'b1;
    step();
    chk("t1_ext_res_hi", 32'(ext_res), 32'd1);
    chk("t1_count_1", 32'(fifo_count), 32'd1);
    found = 1'b0;
    step();
    chk("t1_ext_res_lo", 32'(ext_res), 32'd0);
    chk("t1_sync_valid", 32'(tx_valid), 32'd1);
    chk("t1_sync_byte", 32'(tx_data), 32'hA5);
    for (int i = 1; i < 6; i++) begin
      step();
      chk("t1_valid", 32'(tx_valid), 32'd1);
      chk("t1_byte", 32'(tx_data), 32'(t1[i]));
    end
    step();
    chk("t1_done_valid", 32'(tx_valid), 32'd0);
    chk("t1_done_count", 32'(fifo_count), 32'd0);
    step();
    chk("t1_idle_valid", 32'(tx_valid), 32'd0);

    // same result, sink toggling ready
    f0 = frames_done;
    ready_mode = 2;
    pulse(32'h04030201);
    wait_idle(100);
    chk("t2_frames", 32'(frames_done - f0), 32'd1);

    // found held high: one capture only
    ready_mode = 0;
    ready_manual = 1'b1;
    p0 = ext_pulses;
    f0 = frames_done;
    co_buf = 32'hDEADBEEF;
    found = 1'b1;
    repeat (20) step();
    found = 1'b0;
    repeat (2) step();
    chk("t3_pulses", 32'(ext_pulses - p0), 32'd1);
    wait_idle(100);
    chk("t3_frames", 32'(frames_done - f0), 32'd1);

    // overflow: six events into a four-entry FIFO with the sink stalled
    ready_manual = 1'b0;
    p0 = ext_pulses;
    f0 = frames_done;
    for (int v = 1; v <= 6; v++) pulse({8'hC0, 8'hB0, 8'hA0, 8'(v)});
    step();
    chk("t4_count", 32'(fifo_count), 32'd4);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_drops", 32'(drop_count), 32'd2);
    chk("t4_pulses", 32'(ext_pulses - p0), 32'd6);
    ready_manual = 1'b1;
    wait_idle(200);
    chk("t4_frames", 32'(frames_done - f0), 32'd4);

    // event lands on the checksum-accept edge with three entries stored
    ready_manual = 1'b0;
    f0 = frames_done;
    for (int v = 0; v < 3; v++) pulse(32'h5A5A5A00 | 32'(v + 7));
    ready_manual = 1'b1;
    repeat (5) step();
    co_buf = 32'h77665544;
    found = 1'b1;
    step();
    chk("t5_count", 32'(fifo_count), 32'd3);
    chk("t5_ext_res", 32'(ext_res), 32'd1);
    chk("t5_drops", 32'(drop_count), 32'd2);
    found = 1'b0;
    wait_idle(200);
    chk("t5_frames", 32'(frames_done - f0), 32'd4);

    // reset in the middle of tap byte 2
    ready_manual = 1'b1;
    pulse(32'h0D0C0B0A);
    repeat (3) step();
    chk("t6_mid_byte", 32'(tx_data), 32'h0C);
    #2 res = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    chk("t6_rst_overflow", 32'(overflow), 32'd0);
    chk("t6_rst_drops", 32'(drop_count), 32'd0);
    chk("t6_rst_data", 32'(tx_data), 32'd0);
    step();
    step();
    res = 1'b1;
    pulse(32'h44332211);
    chk("t6_new_valid", 32'(tx_valid), 32'd1);
    chk("t6_new_sync", 32'(tx_data), 32'hA5);
    wait_idle(100);

    // random phase
    ready_mode = 3;
    repeat (300) begin
      found = ($urandom_range(0, 2) == 0);
      co_buf = $urandom;
      step();
    end
    found = 1'b0;
    ready_mode = 0;
    ready_manual = 1'b1;
    wait_idle(400);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/result_reporter.md
Name: result_reporter

Overview:
- Downstream end of the tap-search datapath. Consumes the search engine's `found` / `co_buf` result and drives back its `ext_res` restart request.
- Captures each discovered tap set into a small FIFO and restarts the search.
- Streams every captured tap set out as a framed byte stream over a valid/ready handshake, e.g. to a UART transmitter or a host link.

Parameters:
- NUM_OF_TAPS, 16, number of 8-bit tap indices per result; co_buf width is NUM_OF_TAPS*8.
- DEPTH, 4, FIFO entries (power of two, >=2).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- res  in  1  reset, asynchronous, active-low.
- found  in  1  search-success level from the search engine.
- co_buf  in  NUM_OF_TAPS*8  tap set; valid whenever found is high.
- ext_res  out  1  one-cycle restart pulse to the search engine.
- tx_data  out  8  outgoing byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when tx_valid & tx_ready at a clock edge.
- fifo_count  out  $clog2(DEPTH)+1  stored entries.
- overflow  out  1  sticky: a result was lost because the FIFO was full.
- drop_count  out  8  saturating count of lost results.

Behaviour:
- Reset (res low, asynchronous):
  - Outputs: ext_res=0, tx_valid=0, tx_data=0, fifo_count=0, overflow=0, drop_count=0.
  - Internal: FSM=IDLE, found_q=0, FIFO pointers=0.
  - Takes effect immediately, including mid-frame; the partial frame is abandoned and never resumed.
- Capture:
  - Event = found & ~found_q, where found_q is found registered. A level held high counts once.
  - At the event edge, if the FIFO is not full: write co_buf, fifo_count+1.
  - If the FIFO is full: no write, overflow<=1, drop_count+1 (saturates at 255).
  - ext_res is high for exactly the one cycle following every event edge, whether or not the result was stored.
- Simultaneous push and pop on the same edge: both performed, fifo_count unchanged. A push into a full FIFO in the same edge as a pop still counts as a drop; full is evaluated before the pop.
- FIFO: circular buffer, wrap-around read/write pointers. Entries are not visible to the serializer until the edge after the write.
- Serializer FSM, states IDLE, SYNC, DATA, CHK:
  - IDLE: when fifo_count!=0, go to SYNC. tx_valid=1, tx_data=SYNC_BYTE, byte index i=0, checksum=0.
  - SYNC: on accept, go to DATA. tx_data=head[7:0].
  - DATA: on accept of byte i, checksum^=byte i.
    - If i<NUM_OF_TAPS-1: i+1, tx_data=head[8(i+1)+:8].
    - Otherwise: go to CHK, tx_data=final checksum (XOR of all tap bytes).
  - CHK: on accept, pop the FIFO, tx_valid=0, go to IDLE.
- Frame length NUM_OF_TAPS+2 bytes. Tap byte 0 (co_buf[7:0]) is sent first. Minimum gap between frames is one IDLE cycle.
- Handshake rules:
  - tx_data is stable while tx_valid & ~tx_ready.
  - tx_valid never drops without an accept, except on reset.
  - The FIFO head is not popped until the checksum is accepted, so captures arriving mid-frame do not disturb the frame in flight.
- Latency: event at edge k → fifo_count updated after edge k → tx_valid with SYNC_BYTE after edge k+1 (FIFO previously empty, FSM idle).
- Timing: no combinational path from tx_ready to tx_valid or tx_data. All outputs are registered.

Test Plan:
1. NUM_OF_TAPS=4, co_buf=32'h04030201, found pulses 1 cycle, tx_ready=1 → ext_res high 1 cycle after edge. Bytes accepted on consecutive edges: A5 01 02 03 04 04; fifo_count returns to 0; one IDLE cycle follows.
2. Same input, tx_ready toggled 1010… → identical byte sequence. tx_data is held stable on every ready-low cycle; no byte is duplicated or skipped.
3. found held high 20 cycles → exactly one capture, one ext_res pulse, one frame.
4. DEPTH=4, tx_ready=0, 6 distinct found events (co_buf=1..6 in byte 0) → fifo_count=4, overflow=1, drop_count=2, six ext_res pulses. With ready=1, frames for values 1,2,3,4 only, in order.
5. FIFO holds 3 entries; a new event coincides with the CHK accept edge → fifo_count stays 3, no drop; frames continue in order across pointer wrap.
6. Assert res low in the middle of the DATA byte 2 of a frame → tx_valid, fifo_count, overflow and drop_count are 0 immediately. After release, a new event produces a complete fresh frame starting with A5.
